// File: rtl/index_regfile.sv
// Index-register file: NREG index/limit pairs with load, step, stride-add,
// clear and loop-count operations. There is one command per cycle and an
// independent combinational read port.
module index_regfile #(
   parameter int WIDTH   = 8,
   parameter int NREG    = 4,
   parameter int SEL_W   = 2,
   parameter bit WRAP    = 1'b1,
   parameter bit LIMWRAP = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   input  logic [2:0]       cmd,
   input  logic [SEL_W-1:0] sel,
   input  logic [WIDTH-1:0] din,
   input  logic [SEL_W-1:0] rd_sel,
   output logic [WIDTH-1:0] rd_data,
   output logic             zero,
   output logic             hit,
   output logic             ovf,
   output logic             taken
);

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_INC  = 3'b010;
   localparam logic [2:0] OP_DEC  = 3'b011;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_SLIM = 3'b101;
   localparam logic [2:0] OP_CLR  = 3'b110;
   localparam logic [2:0] OP_LOOP = 3'b111;

   localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   logic [WIDTH-1:0] ix  [NREG];
   logic [WIDTH-1:0] lim [NREG];

   logic [WIDTH-1:0] cur, clim, res, nlim;
   logic [WIDTH:0]   sum;
   logic             we, f_ovf, f_taken;

   // Read port sees registered state only; there is no bypass of a pending write.
   assign rd_data = ix[rd_sel];

   assign cur = ix[sel];
   assign clim = lim[sel];
   assign sum = {1'b0, cur} + {1'b0, din};

   // Compute the next value of the selected pair and the flags for this command.
   always_comb begin
      we      = cmd_valid && (cmd != OP_NOP);
      res     = cur;
      nlim    = clim;
      f_ovf   = 1'b0;
      f_taken = 1'b0;
      case (cmd)
         OP_LOAD: res = din;
         OP_INC: begin
            // Limit wrap takes precedence over the 2^WIDTH wrap/saturate rule.
            if (LIMWRAP && (cur == clim)) begin
               res   = '0;
               f_ovf = 1'b1;
            end else if (cur == MAXV) begin
               res   = WRAP ? '0 : MAXV;
               f_ovf = 1'b1;
            end else begin
               res = cur + ONE;
            end
         end
         OP_DEC: begin
            if (cur == '0) begin
               res   = LIMWRAP ? clim : (WRAP ? MAXV : '0);
               f_ovf = 1'b1;
            end else begin
               res = cur - ONE;
            end
         end
         OP_ADD: begin
            if (sum[WIDTH]) begin
               res   = WRAP ? sum[WIDTH-1:0] : MAXV;
               f_ovf = 1'b1;
            end else begin
               res = sum[WIDTH-1:0];
            end
         end
         OP_SLIM: nlim = din;
         OP_CLR:  res = '0;
         OP_LOOP: begin
            // A counter that has already reached zero stays there and does not branch.
            if (cur != '0) begin
               res     = cur - ONE;
               f_taken = (res != '0);
            end
         end
         default: ;
      endcase
   end

   // Register file and flags: only the selected pair is written. Reset wins over a command.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            ix[i]  <= '0;
            lim[i] <= MAXV;
         end
         zero  <= 1'b1;
         hit   <= 1'b0;
         ovf   <= 1'b0;
         taken <= 1'b0;
      end else if (we) begin
         ix[sel]  <= res;
         lim[sel] <= nlim;
         zero     <= (res == '0);
         hit      <= (res == nlim);
         ovf      <= f_ovf;
         taken    <= f_taken;
      end
   end

endmodule

// File: tb/tb_index_regfile.sv
// Directed bench for index_regfile. Three builds share one command stream:
// wrap (default), saturate (WRAP=0) and limit-wrap (LIMWRAP=1).
module tb_index_regfile;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [2:0] cmd = 3'b000;
   logic [1:0] sel = 2'd0;
   logic [7:0] din = 8'h00;
   logic [1:0] rd_sel = 2'd0;

   logic [7:0] rd_w, rd_s, rd_l;
   logic       zero_w, hit_w, ovf_w, taken_w;
   logic       zero_s, hit_s, ovf_s, taken_s;
   logic       zero_l, hit_l, ovf_l, taken_l;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   index_regfile #(.WIDTH(8), .NREG(4), .SEL_W(2), .WRAP(1'b1), .LIMWRAP(1'b0)) u_wrap (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .sel(sel), .din(din),
      .rd_sel(rd_sel), .rd_data(rd_w), .zero(zero_w), .hit(hit_w), .ovf(ovf_w), .taken(taken_w));

   index_regfile #(.WIDTH(8), .NREG(4), .SEL_W(2), .WRAP(1'b0), .LIMWRAP(1'b0)) u_sat (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .sel(sel), .din(din),
      .rd_sel(rd_sel), .rd_data(rd_s), .zero(zero_s), .hit(hit_s), .ovf(ovf_s), .taken(taken_s));

   index_regfile #(.WIDTH(8), .NREG(4), .SEL_W(2), .WRAP(1'b1), .LIMWRAP(1'b1)) u_lim (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .sel(sel), .din(din),
      .rd_sel(rd_sel), .rd_data(rd_l), .zero(zero_l), .hit(hit_l), .ovf(ovf_l), .taken(taken_l));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one command; returns #1 after the edge that executes it.
   task automatic op(input logic [2:0] c, input logic [1:0] s, input logic [7:0] d);
      cmd_valid = 1'b1; cmd = c; sel = s; din = d;
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd = 3'b000;
   endtask

   task automatic rd(input logic [1:0] s);
      rd_sel = s; #1;
   endtask

   initial begin
      repeat (2) @(posedge clk); #1;
      chk("rst_ix0", rd_w, 8'h00);
      chk("rst_zero", zero_w, 1'b1);
      chk("rst_hit", hit_w, 1'b0);
      chk("rst_ovf", ovf_w, 1'b0);
      chk("rst_taken", taken_w, 1'b0);
      reset = 1'b0;

      // LOAD then INC x3 on pair 2
      rd(2);
      op(3'b001, 2, 8'h10);
      op(3'b010, 2, 8'h00);
      op(3'b010, 2, 8'h00);
      op(3'b010, 2, 8'h00);
      chk("inc3_rd", rd_w, 8'h13);
      chk("inc3_zero", zero_w, 1'b0);
      chk("inc3_ovf", ovf_w, 1'b0);
      chk("inc3_hit", hit_w, 1'b0);
      rd(0); chk("other_ix0", rd_w, 8'h00);
      rd(1); chk("other_ix1", rd_w, 8'h00);
      rd(3); chk("other_ix3", rd_w, 8'h00);

      // INC at all-ones: wrap / saturate / limit-wrap (limit is FF at reset)
      rd(0);
      op(3'b001, 0, 8'hFF);
      op(3'b010, 0, 8'h00);
      chk("incw_rd", rd_w, 8'h00);
      chk("incw_zero", zero_w, 1'b1);
      chk("incw_ovf", ovf_w, 1'b1);
      chk("incs_rd", rd_s, 8'hFF);
      chk("incs_ovf", ovf_s, 1'b1);
      chk("incs_zero", zero_s, 1'b0);
      chk("incl_rd", rd_l, 8'h00);
      chk("incl_ovf", ovf_l, 1'b1);

      // DEC at zero
      op(3'b110, 0, 8'h00);
      op(3'b011, 0, 8'h00);
      chk("decw_rd", rd_w, 8'hFF);
      chk("decw_ovf", ovf_w, 1'b1);
      chk("decs_rd", rd_s, 8'h00);
      chk("decs_ovf", ovf_s, 1'b1);
      chk("decs_zero", zero_s, 1'b1);
      chk("decl_rd", rd_l, 8'hFF);
      chk("decl_hit", hit_l, 1'b1);

      // ADD with and without carry
      rd(1);
      op(3'b001, 1, 8'hF0);
      op(3'b100, 1, 8'h20);
      chk("addw_rd", rd_w, 8'h10);
      chk("addw_ovf", ovf_w, 1'b1);
      chk("adds_rd", rd_s, 8'hFF);
      chk("adds_ovf", ovf_s, 1'b1);
      op(3'b100, 1, 8'h05);
      chk("add5_rd", rd_w, 8'h15);
      chk("add5_ovf", ovf_w, 1'b0);
      chk("add5s_rd", rd_s, 8'hFF);

      // Circular indexing with limit 3 on pair 3
      rd(3);
      op(3'b101, 3, 8'h03);
      chk("slim_hit", hit_l, 1'b0);
      chk("slim_zero", zero_l, 1'b1);
      chk("slim_ix", rd_l, 8'h00);
      op(3'b110, 3, 8'h00);
      op(3'b010, 3, 8'h00); chk("lw1_rd", rd_l, 8'h01); chk("lw1_hit", hit_l, 1'b0);
      op(3'b010, 3, 8'h00); chk("lw2_rd", rd_l, 8'h02);
      op(3'b010, 3, 8'h00); chk("lw3_rd", rd_l, 8'h03); chk("lw3_hit", hit_l, 1'b1);
      chk("lw3_ovf", ovf_l, 1'b0);
      op(3'b010, 3, 8'h00); chk("lw0_rd", rd_l, 8'h00); chk("lw0_ovf", ovf_l, 1'b1);
      chk("lw0_zero", zero_l, 1'b1);
      chk("lw4_wrap_rd", rd_w, 8'h04);
      op(3'b011, 3, 8'h00); chk("ldec_rd", rd_l, 8'h03); chk("ldec_ovf", ovf_l, 1'b1);

      // LOOP countdown from 3 on pair 2, with a hold check on NOP
      rd(2);
      op(3'b001, 2, 8'h03);
      op(3'b111, 2, 8'h00); chk("lp1_rd", rd_w, 8'h02); chk("lp1_taken", taken_w, 1'b1);
      op(3'b111, 2, 8'h00); chk("lp2_rd", rd_w, 8'h01); chk("lp2_taken", taken_w, 1'b1);
      op(3'b000, 2, 8'h00); chk("nop_taken", taken_w, 1'b1); chk("nop_rd", rd_w, 8'h01);
      op(3'b111, 2, 8'h00); chk("lp3_rd", rd_w, 8'h00); chk("lp3_taken", taken_w, 1'b0);
      chk("lp3_zero", zero_w, 1'b1);
      op(3'b111, 2, 8'h00); chk("lp4_rd", rd_w, 8'h00); chk("lp4_taken", taken_w, 1'b0);
      chk("lp4_zero", zero_w, 1'b1); chk("lp4_ovf", ovf_w, 1'b0);
      op(3'b111, 2, 8'h01);
      op(3'b001, 2, 8'h07); chk("load_taken", taken_w, 1'b0);

      // Back-to-back INC on pair 1, no read bypass, reset in mid-burst
      rd(1);
      op(3'b110, 1, 8'h00);
      op(3'b010, 1, 8'h00);
      chk("b2b1_rd", rd_w, 8'h01);
      cmd_valid = 1'b1; cmd = 3'b010; sel = 2'd1; #1;
      chk("nobypass_rd", rd_w, 8'h01);
      @(posedge clk); #1;
      chk("b2b2_rd", rd_w, 8'h02);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; cmd_valid = 1'b0; cmd = 3'b000;
      chk("rstb_rd", rd_w, 8'h00);
      chk("rstb_zero", zero_w, 1'b1);
      chk("rstb_hit", hit_w, 1'b0);
      chk("rstb_ovf", ovf_w, 1'b0);
      chk("rstb_taken", taken_w, 1'b0);
      rd(0); chk("rstb_ix0", rd_w, 8'h00);
      rd(1);
      op(3'b010, 1, 8'h00);
      chk("postrst_rd", rd_w, 8'h01);
      chk("postrst_zero", zero_w, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
